// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches on memory port 1 and
// buffers up to two returned {pc, ir} pairs for the decode stage. A redirect
// flushes everything and restarts fetch at the new target.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        DEC_READY,
    output logic [31:0] MEM_ADDR1,
    output logic        MEM_READ1,
    input  logic [31:0] MEM_DOUT1,
    output logic        IF_VALID,
    output logic [31:0] IF_IR,
    output logic [31:0] IF_PC
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
    localparam logic [2:0]  FULL     = 3'(DEPTH);

    logic [31:0] fpc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [1:0]  count;
    logic [31:0] head_pc;
    logic [31:0] head_ir;
    logic [31:0] tail_pc;
    logic [31:0] tail_ir;
    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  unused_redirect_lsbs;

    // Targets are word aligned; the low bits of the redirect address are dropped.
    assign unused_redirect_lsbs = REDIRECT_PC[1:0];

    // A redirect hides the queue in the same cycle so no stale PC reaches decode.
    assign IF_VALID = (count != 2'd0) && !REDIRECT;
    assign pop      = IF_VALID && DEC_READY;
    // Inflight data is only captured when no redirect is discarding it.
    assign push     = inflight && !REDIRECT;
    // Issuing while popping is safe: the slot freed by the pop absorbs the new fetch,
    // so count + inflight never exceeds the queue depth.
    assign issue    = !RST && !REDIRECT &&
                      ((({1'b0, count} + {2'b00, inflight}) < FULL) || pop);

    assign MEM_READ1 = issue;
    assign MEM_ADDR1 = fpc;
    assign IF_IR     = IF_VALID ? head_ir : NOP;
    assign IF_PC     = IF_VALID ? head_pc : 32'h0000_0000;

    // Control state: fetch PC, inflight flag and queue occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fpc      <= START_PC;
            inflight <= 1'b0;
            count    <= 2'd0;
        end else if (REDIRECT) begin
            fpc      <= {REDIRECT_PC[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc <= fpc + 32'd4;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Queue payload: head is always the oldest entry, tail the second one.
    always_ff @(posedge CLK) begin
        if (issue) begin
            inflight_pc <= fpc;
        end
        unique case ({push, pop})
            2'b10: begin
                if (count == 2'd0) begin
                    head_pc <= inflight_pc;
                    head_ir <= MEM_DOUT1;
                end else begin
                    tail_pc <= inflight_pc;
                    tail_ir <= MEM_DOUT1;
                end
            end
            2'b01: begin
                head_pc <= tail_pc;
                head_ir <= tail_ir;
            end
            2'b11: begin
                if (count == 2'd1) begin
                    head_pc <= inflight_pc;
                    head_ir <= MEM_DOUT1;
                end else begin
                    head_pc <= tail_pc;
                    head_ir <= tail_ir;
                    tail_pc <= inflight_pc;
                    tail_ir <= MEM_DOUT1;
                end
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    // Overflow must be impossible given the issue throttle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(push && !pop && ({1'b0, count} == FULL)))
                else $error("fetch_queue overflow: push into a full queue");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A timestamp-based reference model
// predicts every cycle's outputs: each fetch issued in cycle t becomes
// deliverable from cycle t+2, in issue order, and at most two fetches may be
// outstanding unless decode is consuming one in the same cycle.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        DEC_READY;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1;
    logic        IF_VALID;
    logic [31:0] IF_IR;
    logic [31:0] IF_PC;

    int tests = 0;
    int fails = 0;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .DEC_READY(DEC_READY), .MEM_ADDR1(MEM_ADDR1), .MEM_READ1(MEM_READ1),
        .MEM_DOUT1(MEM_DOUT1), .IF_VALID(IF_VALID), .IF_IR(IF_IR), .IF_PC(IF_PC)
    );

    always #5 CLK = ~CLK;

    // Instruction memory: mem[a] = a ^ KEY, one cycle read latency.
    always @(posedge CLK) begin
        MEM_DOUT1 <= MEM_READ1 ? (MEM_ADDR1 ^ KEY) : 32'hDEAD_BEEF;
    end

    // Reference model state
    logic [31:0] m_pc[$];
    int          m_t[$];
    logic [31:0] m_fpc;
    int          m_cyc;
    logic        e_valid, e_pop, e_read;
    logic [97:0] obs, exp_v;

    task automatic model_reset();
        m_pc.delete();
        m_t.delete();
        m_fpc = {RESET_PC[31:2], 2'b00};
        m_cyc = 0;
    endtask

    // Drive one cycle's inputs, sample outputs, compute model expectation, advance model.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic [31:0] e_pc, e_ir;
        @(negedge CLK);
        DEC_READY   = rdy;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        #1;
        e_valid = !redir && (m_pc.size() > 0) && (m_t[0] + 2 <= m_cyc);
        e_pop   = e_valid && rdy;
        e_read  = !redir && ((m_pc.size() < 2) || e_pop);
        e_pc    = e_valid ? m_pc[0] : 32'h0;
        e_ir    = e_valid ? (m_pc[0] ^ KEY) : NOP;
        exp_v   = {e_read, m_fpc, e_valid, e_pc, e_ir};
        obs     = {MEM_READ1, MEM_ADDR1, IF_VALID, IF_PC, IF_IR};
        if (redir) begin
            m_pc.delete();
            m_t.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (e_pop) begin
                void'(m_pc.pop_front());
                void'(m_t.pop_front());
            end
            if (e_read) begin
                m_pc.push_back(m_fpc);
                m_t.push_back(m_cyc);
                m_fpc = m_fpc + 32'd4;
            end
        end
        m_cyc++;
    endtask

    task automatic test_reset();
        RST = 1'b1; DEC_READY = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        tests++;
        if ({MEM_READ1, IF_VALID, IF_IR, IF_PC, MEM_ADDR1} !== {1'b0, 1'b0, NOP, 32'h0, RESET_PC}) begin
            fails++;
            $display("FAIL reset_state got rd=%b v=%b ir=%h pc=%h addr=%h want rd=0 v=0 ir=%h pc=0 addr=%h",
                     MEM_READ1, IF_VALID, IF_IR, IF_PC, MEM_ADDR1, NOP, RESET_PC);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_release();
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL release_vec cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (i == 1) begin
                tests++;
                if (!(MEM_READ1 === 1'b1 && MEM_ADDR1 === RESET_PC && IF_VALID === 1'b0)) begin
                    fails++;
                    $display("FAIL release_first_issue got rd=%b addr=%h v=%b want rd=1 addr=%h v=0",
                             MEM_READ1, MEM_ADDR1, IF_VALID, RESET_PC);
                end
            end
            if (i == 2) begin
                tests++;
                if (IF_VALID !== 1'b0) begin
                    fails++;
                    $display("FAIL release_cyc2_valid got %b want 0", IF_VALID);
                end
            end
            if (i >= 3) begin
                tests++;
                if (!(IF_VALID === 1'b1 && IF_PC === RESET_PC + 32'(4 * (i - 3)) &&
                      IF_IR === ((RESET_PC + 32'(4 * (i - 3))) ^ KEY))) begin
                    fails++;
                    $display("FAIL release_stream cyc=%0d got v=%b pc=%h ir=%h want v=1 pc=%h",
                             i, IF_VALID, IF_PC, IF_IR, RESET_PC + 32'(4 * (i - 3)));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] addr0, pc0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (i == 0) begin
                addr0 = m_fpc;
                pc0   = m_pc[0];
            end
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL stall_vec cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            tests++;
            if (!(MEM_READ1 === 1'b0 && MEM_ADDR1 === addr0 && IF_VALID === 1'b1 &&
                  IF_PC === pc0 && IF_IR === (pc0 ^ KEY))) begin
                fails++;
                $display("FAIL stall_hold cyc=%0d got rd=%b addr=%h v=%b pc=%h want rd=0 addr=%h v=1 pc=%h",
                         i, MEM_READ1, MEM_ADDR1, IF_VALID, IF_PC, addr0, pc0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL stall_release_vec cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            tests++;
            if (!(IF_VALID === 1'b1 && IF_PC === pc0 + 32'(4 * i))) begin
                fails++;
                $display("FAIL stall_release_seq cyc=%0d got v=%b pc=%h want v=1 pc=%h",
                         i, IF_VALID, IF_PC, pc0 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0103);
        tests++;
        if (!(IF_VALID === 1'b0 && MEM_READ1 === 1'b0 && IF_IR === NOP && IF_PC === 32'h0)) begin
            fails++;
            $display("FAIL redirect_cycle got v=%b rd=%b ir=%h pc=%h want v=0 rd=0 ir=%h pc=0",
                     IF_VALID, MEM_READ1, IF_IR, IF_PC, NOP);
        end
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL redirect_vec cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (i == 1) begin
                tests++;
                if (!(MEM_READ1 === 1'b1 && MEM_ADDR1 === 32'h0000_0100)) begin
                    fails++;
                    $display("FAIL redirect_issue got rd=%b addr=%h want rd=1 addr=00000100", MEM_READ1, MEM_ADDR1);
                end
            end
            if (i == 2) begin
                tests++;
                if (IF_VALID !== 1'b0) begin
                    fails++;
                    $display("FAIL redirect_no_stale got v=%b pc=%h want v=0", IF_VALID, IF_PC);
                end
            end
            if (i == 3) begin
                tests++;
                if (!(IF_VALID === 1'b1 && IF_PC === 32'h0000_0100 && IF_IR === (32'h0000_0100 ^ KEY))) begin
                    fails++;
                    $display("FAIL redirect_first got v=%b pc=%h ir=%h want v=1 pc=00000100", IF_VALID, IF_PC, IF_IR);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 32'h0000_0300);
        for (int i = 0; i < 8 && !seen; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL b2b_vec cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (IF_VALID === 1'b1) begin
                seen = 1;
                tests++;
                if (IF_PC !== 32'h0000_0300) begin
                    fails++;
                    $display("FAIL b2b_first_pc got %h want 00000300", IF_PC);
                end
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL b2b_timeout got no valid instruction want pc 00000300");
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        int n = 0;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 10 && n < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL wrap_vec cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (IF_VALID === 1'b1) begin
                tests++;
                if (IF_PC !== want[n]) begin
                    fails++;
                    $display("FAIL wrap_seq idx=%0d got %h want %h", n, IF_PC, want[n]);
                end
                n++;
            end
        end
        if (n < 3) begin
            tests++;
            fails++;
            $display("FAIL wrap_timeout got %0d deliveries want 3", n);
        end
    endtask

    task automatic test_async_reset();
        repeat (4) step(1'b1, 1'b0, 32'h0);
        #2;
        RST = 1'b1;
        #1;
        tests++;
        if ({MEM_READ1, IF_VALID, IF_IR, IF_PC, MEM_ADDR1} !== {1'b0, 1'b0, NOP, 32'h0, RESET_PC}) begin
            fails++;
            $display("FAIL async_reset got rd=%b v=%b ir=%h pc=%h addr=%h want rd=0 v=0 ir=%h pc=0 addr=%h",
                     MEM_READ1, IF_VALID, IF_IR, IF_PC, MEM_ADDR1, NOP, RESET_PC);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL async_restart_vec cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (i == 1) begin
                tests++;
                if (!(MEM_READ1 === 1'b1 && MEM_ADDR1 === RESET_PC)) begin
                    fails++;
                    $display("FAIL async_restart_addr got rd=%b addr=%h want rd=1 addr=%h", MEM_READ1, MEM_ADDR1, RESET_PC);
                end
            end
        end
    endtask

    task automatic test_random();
        logic        rdy, redir;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 29) == 0);
            rpc   = $urandom;
            step(rdy, redir, rpc);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL random_vec cyc=%0d rdy=%b redir=%b got=%h want=%h", i, rdy, redir, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
